// File: rtl/tracker_pkg.sv
// Shared encodings for the line tracker: motion codes and FSM states.
// Imported by line_tracker_ctrl.
package tracker_pkg;

  localparam logic [1:0] TURN_LEFT   = 2'b00;
  localparam logic [1:0] TURN_RIGHT  = 2'b01;
  localparam logic [1:0] GO_STRAIGHT = 2'b10;
  localparam logic [1:0] STOP_STATE  = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    HALT   = 2'd0,
    TRACK  = 2'd1,
    SEARCH = 2'd2
  } fsm_t;

endpackage

// File: rtl/sensor_debounce.sv
// One tracker channel: synchroniser flop, persistence counter and
// filtered bit that only follows changes lasting DEBOUNCE cycles.
module sensor_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing samples; accept on the last one.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        filt_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, counter and filtered bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 1'b0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= raw_i;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/line_tracker_ctrl.sv
// Line-following decision block: filtered sensors -> error -> motion.
// Define TRACKER_SEARCH_EN to enable the timed line-recovery search.
module line_tracker_ctrl
  import tracker_pkg::*;
#(
  parameter int N_SENSORS    = 3,
  parameter int DEBOUNCE     = 4,
  parameter int LOST_TIMEOUT = 1024,
  parameter int DEADBAND     = 0,
  localparam int MAG_W       = $clog2(N_SENSORS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SENSORS-1:0] sensor,
  output logic [1:0]           state,
  output logic [MAG_W-1:0]     turn_mag,
  output logic                 lost
);

  localparam int EW = $clog2(2 * N_SENSORS) + 1;

  if ((N_SENSORS < 3) || ((N_SENSORS % 2) == 0)) begin : g_chk_n
    $error("N_SENSORS must be odd and >= 3");
  end
  if (DEBOUNCE < 1) begin : g_chk_db
    $error("DEBOUNCE must be >= 1");
  end
  if (LOST_TIMEOUT < 1) begin : g_chk_to
    $error("LOST_TIMEOUT must be >= 1");
  end

  logic [N_SENSORS-1:0] filt;

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_ch
    sensor_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw_i (sensor[g]),
      .filt_o(filt[g])
    );
  end

  logic [MAG_W-1:0] l_idx, r_idx;
  logic [EW-1:0]    err, abs_err;
  logic             any, in_band, err_neg;

  // Outermost set bits give the signed line position error.
  always_comb begin
    l_idx = '0;
    r_idx = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (filt[i]) l_idx = i[MAG_W-1:0];
    end
    for (int i = N_SENSORS - 1; i >= 0; i--) begin
      if (filt[i]) r_idx = i[MAG_W-1:0];
    end
    err     = EW'(l_idx) + EW'(r_idx) - EW'(N_SENSORS - 1);
    err_neg = err[EW-1];
    abs_err = err_neg ? (EW'(0) - err) : err;
    in_band = (int'(abs_err) <= DEADBAND);
    any     = |filt;
  end

  fsm_t             fsm_q;
  logic [1:0]       state_q;
  logic [MAG_W-1:0] mag_q;
  logic             lost_q;

`ifdef TRACKER_SEARCH_EN
  localparam int CW = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;
  logic          dir_q;
  logic [CW-1:0] cnt_q;
`endif

  // Mode FSM with registered motion outputs; seeing the line always wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= HALT;
      state_q <= STOP_STATE;
      mag_q   <= '0;
      lost_q  <= 1'b0;
`ifdef TRACKER_SEARCH_EN
      dir_q   <= DIR_LEFT;
      cnt_q   <= '0;
`endif
    end else if (any) begin
      fsm_q  <= TRACK;
      lost_q <= 1'b0;
`ifdef TRACKER_SEARCH_EN
      cnt_q  <= '0;
`endif
      if (in_band) begin
        state_q <= GO_STRAIGHT;
        mag_q   <= '0;
      end else if (!err_neg) begin
        state_q <= TURN_LEFT;
        mag_q   <= MAG_W'(abs_err);
`ifdef TRACKER_SEARCH_EN
        dir_q   <= DIR_LEFT;
`endif
      end else begin
        state_q <= TURN_RIGHT;
        mag_q   <= MAG_W'(abs_err);
`ifdef TRACKER_SEARCH_EN
        dir_q   <= DIR_RIGHT;
`endif
      end
    end else begin
      unique case (fsm_q)
        TRACK: begin
`ifdef TRACKER_SEARCH_EN
          fsm_q   <= SEARCH;
          state_q <= (dir_q == DIR_RIGHT) ? TURN_RIGHT : TURN_LEFT;
          mag_q   <= MAG_W'(N_SENSORS - 1);
          cnt_q   <= '0;
`else
          fsm_q   <= HALT;
          state_q <= STOP_STATE;
          mag_q   <= '0;
          lost_q  <= 1'b1;
`endif
        end
`ifdef TRACKER_SEARCH_EN
        SEARCH: begin
          if (cnt_q == CW'(LOST_TIMEOUT - 1)) begin
            fsm_q   <= HALT;
            state_q <= STOP_STATE;
            mag_q   <= '0;
            lost_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          fsm_q   <= HALT;
          state_q <= STOP_STATE;
          mag_q   <= '0;
        end
      endcase
    end
  end

  assign state    = state_q;
  assign turn_mag = mag_q;
  assign lost     = lost_q;

endmodule

// File: doc/line_tracker_ctrl.md
# line_tracker_ctrl

Parametrised line-following decision block for the car: takes N debounced infrared tracker channels, computes a signed line-position error, and drives the 2-bit motion state consumed by the motor controller. It adds three things to a fixed three-sensor policy: per-channel glitch filtering, a turn-magnitude output, and a timed search mode that recovers a briefly lost line. It sits between the sensor pins and the motor/PWM logic.

## Interface
- `N_SENSORS`, default 3: number of tracker channels; must be odd and ≥3.
- `DEBOUNCE`, default 4: consecutive cycles a raw change must persist before it is accepted; must be ≥1.
- `LOST_TIMEOUT`, default 1024: cycles spent in SEARCH before halting; must be ≥1.
- `DEADBAND`, default 0: any |error| ≤ DEADBAND is treated as straight.
- `clk`, input, 1: system clock. This is the only clock.
- `reset`, input, 1: synchronous, active-high reset.
- `sensor`, input, N_SENSORS: raw channels, 1 = line detected. Bit N_SENSORS-1 is leftmost and bit 0 is rightmost.
- `state`, output, 2: 00 turn_left, 01 turn_right, 10 go_straight, 11 stop.
- `turn_mag`, output, MAG_W = $clog2(N_SENSORS): unsigned turn strength.
- `lost`, output, 1: high while halted because the line was lost.

## Operation
- Input stage: each channel passes through one synchroniser flop, then a debounce counter.
  - The filtered bit updates when the synchronised value has differed from it for DEBOUNCE consecutive edges.
  - Any agreeing sample clears that channel's counter.
- Error calculation, when at least one filtered bit is set:
  - L is the index of the highest set bit and R is the index of the lowest set bit.
  - err = L + R − (N_SENSORS−1), signed, width $clog2(2·N_SENSORS)+1. The range is ±(N_SENSORS−1).
  - Positive err means the line is to the left. A non-contiguous pattern such as 101 gives err = 0. All-ones gives err = 0.
- FSM states are HALT, TRACK and SEARCH. On reset the FSM enters HALT.
  - HALT: state=11, turn_mag=0. Go to TRACK when any filtered bit is set. lost holds its value until that transition, then clears.
  - TRACK, |err| ≤ DEADBAND: state=10, turn_mag=0.
  - TRACK, err > DEADBAND: state=00, turn_mag=|err|.
  - TRACK, err < −DEADBAND: state=01, turn_mag=|err|.
  - TRACK, all filtered bits 0: go to SEARCH (see Configuration).
  - TRACK side tracking: last_dir records the sign of the most recent non-deadband err. Its reset value is left.
  - SEARCH: state = turn toward last_dir, turn_mag = N_SENSORS−1. The search counter counts up from 0.
  - SEARCH, any filtered bit set: go to TRACK and clear the counter.
  - SEARCH, counter reaches LOST_TIMEOUT−1: go to HALT with lost=1.
  - SEARCH, line regained on the same edge as the timeout: TRACK wins and lost stays 0.
- Reset at any point clears the FSM, all counters, filtered bits and last_dir, and drives all outputs to their reset values.

## Timing
- Reset values: state=11, turn_mag=0, lost=0. filtered=0, last_dir=left.
- All outputs are registered.
- Latency: a raw change held stable is reflected on `state` at the (DEBOUNCE+2)th rising edge after it appears. That is 1 synchroniser edge, DEBOUNCE filter edges, and 1 FSM/output edge.
- A raw pulse shorter than DEBOUNCE cycles never reaches `state`.
- SEARCH lasts exactly LOST_TIMEOUT cycles before `state` becomes 11 and `lost` becomes 1 on the same edge.
- The line-regain decision is taken on the edge after the filtered bit sets.
- Inputs have no handshake. Outputs update at most once per cycle.

## Configuration
- `TRACKER_SEARCH_EN` defined: SEARCH is implemented as described above.
- `TRACKER_SEARCH_EN` undefined:
  - SEARCH, its counter, last_dir and the LOST_TIMEOUT logic are not generated.
  - TRACK with all filtered bits 0 goes directly to HALT with lost=1, on the same edge TRACK would otherwise have entered SEARCH.
  - All other behaviour is identical.

## Structure
- Package `tracker_pkg`:
  - state encodings TURN_LEFT=2'b00, TURN_RIGHT=2'b01, GO_STRAIGHT=2'b10, STOP_STATE=2'b11;
  - FSM state constants HALT, TRACK, SEARCH.
- Sub-module `sensor_debounce`: one channel consisting of the synchroniser, counter and filtered bit, parameter DEBOUNCE. It is instantiated N_SENSORS times in a generate loop.
- Top level contains the error computation, the FSM and the output registers.

## Test plan
All scenarios use N_SENSORS=3, DEBOUNCE=4, LOST_TIMEOUT=16, DEADBAND=0, with TRACKER_SEARCH_EN defined unless stated.
- Reset for 2 cycles with sensor=3'b010: state=11, turn_mag=0, lost=0 during reset. state=10 at the 6th edge after reset is released.
- sensor 010→110 → state=00, turn_mag=1. Then 100 → state=00, turn_mag=2. Then 011 → state=01, turn_mag=1. Then 101 → state=10, turn_mag=0.
- Hold 010 stable, then apply a 000 glitch for 3 cycles → state stays 10 throughout. The same glitch for 4 cycles → SEARCH is entered.
- Sequence 100 then 000 held: state=00 and turn_mag=2 for 16 cycles, then state=11 and lost=1. Then 001 → state=01, lost=0 after 6 edges.
- In SEARCH, apply 010 timed so it is accepted on the final count → TRACK, state=10, lost never asserts. Reset mid-SEARCH → state=11, last_dir=left.
- TRACKER_SEARCH_EN undefined, 010 then 000 → state=11 and lost=1 at the 6th edge, with no turning cycles.
